block_map: RTL and testbench
============================

// Module: block_map
// PURPOSE
//  Storage and responder for the playfield brick grid (10 cols x 30 rows, 32x16-pixel cells).
//  Answers the renderer's sel_row/sel_col lookups with a 3-bit block code.
//  Also applies ball-hit updates through a valid/ready handshake and loads level patterns.
//  Maintains the count of remaining bricks. Sits between game logic and the brick renderer.
// PARAMETERS
//  ROWS   30  grid rows (row index 0..ROWS-1)
//  COLS   10  grid columns (col index 0..COLS-1)
//  IDX_W  5   width of row/col indices
// PORTS
//  clk          in   1      system clock
//  rst_n        in   1      asynchronous active-low reset
//  sel_row      in   5      renderer lookup row
//  sel_col      in   5      renderer lookup col
//  block        out  3      code at (sel_row,sel_col); combinational read; 000 if index out of range
//  level_load   in   1      pulse: start loading pattern level_sel
//  level_sel    in   2      level pattern number, sampled with level_load
//  busy         out  1      high while loading
//  hit_valid    in   1      hit request; hold until accepted
//  hit_row      in   5      hit cell row
//  hit_col      in   5      hit cell col
//  hit_ready    out  1      = (state==IDLE) && !level_load
//  hit_done     out  1      1-cycle pulse, the cycle after accept
//  hit_code     out  3      code of the hit cell before the update; valid with hit_done
//  remaining    out  9      count of non-zero cells
//  cleared      out  1      1-cycle pulse when remaining goes 1->0 through a hit
// BEHAVIOUR
//  Codes: 000 empty; 0cc small brick (cc!=00); 1cc large brick.
//  Reset: all cells 000; remaining=0; busy=0; hit_done=0; hit_code=000; cleared=0; state IDLE.
//  FSM IDLE->LOAD on level_load. LOAD writes one cell per cycle, row-major from (0,0) to (ROWS-1,COLS-1).
//  LOAD then returns to IDLE: 300 cycles, busy high throughout.
//  level_load while in LOAD restarts at (0,0) with the new level_sel (restart mid-operation).
//  LOAD zeroes remaining in its first cycle, then adds 1 for each non-zero code written.
//  Hit accept = hit_valid & hit_ready; the cell is updated at that clock edge:
//    small brick -> 000 (remaining-1);
//    large 1cc -> 0cc, except 100 -> 001 (remaining unchanged);
//    empty -> unchanged.
//  Out-of-range hit (row>=ROWS or col>=COLS): accepted, no write, hit_code=000.
//  level_load together with hit_valid: the load wins; the hit is not accepted and waits.
//  Renderer reads never stall. During LOAD they return the cell contents as written so far.
//  Level patterns, for rows 0..29, all cells not listed are 000:
//    L0: rows 2-5 = 101, rows 6-7 = 010 (60 bricks).
//    L1: rows 2-9, cells with (row+col) even = 111 (40 bricks).
//    L2: row 4 = 001 (10 bricks).
//    L3: every cell 100 (300 bricks).
// CONFIGURATION
//  BLOCK_MAP_SCORE_EN defined:
//    adds output score[15:0], reset 0, also cleared at the start of LOAD;
//    +1 per small brick removed, +2 per large brick downgraded; saturates at 16'hFFFF.
//  BLOCK_MAP_SCORE_EN undefined: no score port and no score logic.
// STRUCTURE
//  block_map_pkg: code constants (BLK_EMPTY etc.), ROWS/COLS, FSM state encoding.
//  Sub-module block_level_rom: combinational (level,row,col) -> code pattern generator.
// TESTING
//  Reset, then read every cell -> block=000, remaining=0, busy=0, hit_ready=1.
//  level_load L0 -> busy for 300 cycles; remaining=60; (3,4)=101, (6,0)=010, (8,0)=000.
//  After L0: hit (3,4) -> hit_done next cycle, hit_code=101, cell=001; remaining 60.
//    Hit (3,4) again -> hit_code=001, cell=000, remaining 59.
//  L2 loaded: hit all 10 cells of row 4 -> remaining 0; cleared pulses once, on the 10th hit.
//    Hit (31,0) -> hit_code=000, no change.
//  level_load L3 at cycle 100 of an L1 load -> restart; after 300 cycles remaining=300, (0,1)=100.
//    hit_valid held during load is accepted only after busy falls.

Source files
------------

// File: rtl/block_map_pkg.sv
// Brick grid constants: cell codes, grid geometry, load FSM states and the hit-downgrade rule.
package block_map_pkg;

  localparam int GRID_ROWS  = 30;
  localparam int GRID_COLS  = 10;
  localparam int GRID_IDX_W = 5;

  // 000 empty, 0cc small brick, 1cc large brick
  localparam logic [2:0] BLK_EMPTY  = 3'b000;
  localparam logic [2:0] BLK_SMALL1 = 3'b001;
  localparam logic [2:0] BLK_SMALL2 = 3'b010;
  localparam logic [2:0] BLK_LARGE0 = 3'b100;
  localparam logic [2:0] BLK_LARGE1 = 3'b101;
  localparam logic [2:0] BLK_LARGE3 = 3'b111;

  typedef enum logic {ST_IDLE, ST_LOAD} state_t;

  // Large 100 would become 000 by the plain rule, so it degrades to the small 001 instead.
  function automatic logic [2:0] blk_after_hit(input logic [2:0] code);
    if (code == BLK_LARGE0) begin
      return BLK_SMALL1;
    end else if (code[2]) begin
      return {1'b0, code[1:0]};
    end else begin
      return BLK_EMPTY;
    end
  endfunction

endpackage

// File: rtl/block_level_rom.sv
// Level pattern generator: (level,row,col) -> block code, purely combinational.
// No state, no latency, no flow control.
module block_level_rom
  import block_map_pkg::*;
#(
  parameter int IDX_W = GRID_IDX_W
) (
  input  logic [1:0]       level,
  input  logic [IDX_W-1:0] row,
  input  logic [IDX_W-1:0] col,
  output logic [2:0]       code
);

  logic checker_even;

  always_comb begin
    code         = BLK_EMPTY;
    checker_even = ((row ^ col) & IDX_W'(1)) == '0;
    case (level)
      2'd0: begin
        if (row >= IDX_W'(2) && row <= IDX_W'(5)) begin
          code = BLK_LARGE1;
        end else if (row >= IDX_W'(6) && row <= IDX_W'(7)) begin
          code = BLK_SMALL2;
        end
      end
      2'd1: begin
        if (row >= IDX_W'(2) && row <= IDX_W'(9) && checker_even) begin
          code = BLK_LARGE3;
        end
      end
      2'd2: begin
        if (row == IDX_W'(4)) begin
          code = BLK_SMALL1;
        end
      end
      default: code = BLK_LARGE0;
    endcase
  end

endmodule

// File: rtl/block_map.sv
// Brick grid store: combinational renderer read, hit result one cycle after accept, 300-cycle level load.
// hit_ready is low while loading or while level_load is asserted; BLOCK_MAP_SCORE_EN adds the score output.
module block_map
  import block_map_pkg::*;
#(
  parameter int ROWS  = GRID_ROWS,
  parameter int COLS  = GRID_COLS,
  parameter int IDX_W = GRID_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] sel_row,
  input  logic [IDX_W-1:0] sel_col,
  output logic [2:0]       block,
  input  logic             level_load,
  input  logic [1:0]       level_sel,
  output logic             busy,
  input  logic             hit_valid,
  input  logic [IDX_W-1:0] hit_row,
  input  logic [IDX_W-1:0] hit_col,
  output logic             hit_ready,
  output logic             hit_done,
  output logic [2:0]       hit_code,
  output logic [8:0]       remaining,
  output logic             cleared
`ifdef BLOCK_MAP_SCORE_EN
  ,
  output logic [15:0]      score
`endif
);

  localparam int               CELLS    = ROWS * COLS;
  localparam int               AW       = $clog2(CELLS);
  localparam logic [IDX_W-1:0] ROW_LIM  = IDX_W'(ROWS);
  localparam logic [IDX_W-1:0] COL_LIM  = IDX_W'(COLS);
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);
  localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(COLS - 1);

  state_t           state_q, state_d;
  logic [2:0]       cells_q [CELLS];
  logic [2:0]       cells_d [CELLS];
  logic [IDX_W-1:0] ld_row_q, ld_row_d;
  logic [IDX_W-1:0] ld_col_q, ld_col_d;
  logic [1:0]       lvl_q, lvl_d;
  logic [8:0]       remaining_q, remaining_d;
  logic             hit_done_q, hit_done_d;
  logic [2:0]       hit_code_q, hit_code_d;
  logic             cleared_q, cleared_d;
  logic [2:0]       rom_code, hit_cur;
  logic [AW-1:0]    sel_idx, hit_idx, ld_idx;
  logic             sel_in, hit_in, ld_first;
`ifdef BLOCK_MAP_SCORE_EN
  logic [15:0]      score_q, score_d;
`endif

  block_level_rom #(.IDX_W(IDX_W)) u_rom (
    .level (lvl_q),
    .row   (ld_row_q),
    .col   (ld_col_q),
    .code  (rom_code)
  );

  assign sel_idx  = AW'(sel_row) * AW'(COLS) + AW'(sel_col);
  assign hit_idx  = AW'(hit_row) * AW'(COLS) + AW'(hit_col);
  assign ld_idx   = AW'(ld_row_q) * AW'(COLS) + AW'(ld_col_q);
  assign sel_in   = (sel_row < ROW_LIM) && (sel_col < COL_LIM);
  assign hit_in   = (hit_row < ROW_LIM) && (hit_col < COL_LIM);
  assign ld_first = (ld_row_q == '0) && (ld_col_q == '0);
  assign hit_cur  = cells_q[hit_idx];

  assign block     = sel_in ? cells_q[sel_idx] : BLK_EMPTY;
  assign busy      = (state_q == ST_LOAD);
  assign hit_ready = (state_q == ST_IDLE) && !level_load;
  assign hit_done  = hit_done_q;
  assign hit_code  = hit_code_q;
  assign remaining = remaining_q;
  assign cleared   = cleared_q;
`ifdef BLOCK_MAP_SCORE_EN
  assign score     = score_q;
`endif

  always_comb begin
    state_d     = state_q;
    cells_d     = cells_q;
    ld_row_d    = ld_row_q;
    ld_col_d    = ld_col_q;
    lvl_d       = lvl_q;
    remaining_d = remaining_q;
    hit_done_d  = 1'b0;
    hit_code_d  = hit_code_q;
    cleared_d   = 1'b0;
`ifdef BLOCK_MAP_SCORE_EN
    score_d     = score_q;
`endif
    if (level_load) begin
      // A new load (or a restart) takes this cycle to latch the level; writing begins next cycle.
      state_d  = ST_LOAD;
      ld_row_d = '0;
      ld_col_d = '0;
      lvl_d    = level_sel;
    end else if (state_q == ST_LOAD) begin
      cells_d[ld_idx] = rom_code;
      remaining_d     = (ld_first ? 9'd0 : remaining_q) + 9'(|rom_code);
`ifdef BLOCK_MAP_SCORE_EN
      if (ld_first) score_d = '0;
`endif
      if (ld_col_q == LAST_COL) begin
        ld_col_d = '0;
        if (ld_row_q == LAST_ROW) begin
          state_d = ST_IDLE;
        end else begin
          ld_row_d = ld_row_q + IDX_W'(1);
        end
      end else begin
        ld_col_d = ld_col_q + IDX_W'(1);
      end
    end else if (hit_valid) begin
      hit_done_d = 1'b1;
      hit_code_d = hit_in ? hit_cur : BLK_EMPTY;
      if (hit_in) begin
        cells_d[hit_idx] = blk_after_hit(hit_cur);
        if (hit_cur != BLK_EMPTY && !hit_cur[2]) begin
          remaining_d = remaining_q - 9'd1;
          cleared_d   = (remaining_q == 9'd1);
`ifdef BLOCK_MAP_SCORE_EN
          score_d     = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
`endif
        end
`ifdef BLOCK_MAP_SCORE_EN
        else if (hit_cur[2]) begin
          score_d = (score_q > 16'hFFFD) ? 16'hFFFF : score_q + 16'd2;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      for (int i = 0; i < CELLS; i++) cells_q[i] <= BLK_EMPTY;
      ld_row_q    <= '0;
      ld_col_q    <= '0;
      lvl_q       <= '0;
      remaining_q <= '0;
      hit_done_q  <= 1'b0;
      hit_code_q  <= BLK_EMPTY;
      cleared_q   <= 1'b0;
`ifdef BLOCK_MAP_SCORE_EN
      score_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cells_q     <= cells_d;
      ld_row_q    <= ld_row_d;
      ld_col_q    <= ld_col_d;
      lvl_q       <= lvl_d;
      remaining_q <= remaining_d;
      hit_done_q  <= hit_done_d;
      hit_code_q  <= hit_code_d;
      cleared_q   <= cleared_d;
`ifdef BLOCK_MAP_SCORE_EN
      score_q     <= score_d;
`endif
    end
  end

endmodule

// File: tb/tb_block_map.sv
// Randomized bench for block_map against a cell-array model, plus literal spot checks of the model.
module tb_block_map;

  logic       clk;
  logic       rst_n;
  logic [4:0] sel_row, sel_col, hit_row, hit_col;
  logic [2:0] block, hit_code;
  logic       level_load, busy, hit_valid, hit_ready, hit_done, cleared;
  logic [1:0] level_sel;
  logic [8:0] remaining;
`ifdef BLOCK_MAP_SCORE_EN
  logic [15:0] score;
`endif

  block_map dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel_row    (sel_row),
    .sel_col    (sel_col),
    .block      (block),
    .level_load (level_load),
    .level_sel  (level_sel),
    .busy       (busy),
    .hit_valid  (hit_valid),
    .hit_row    (hit_row),
    .hit_col    (hit_col),
    .hit_ready  (hit_ready),
    .hit_done   (hit_done),
    .hit_code   (hit_code),
    .remaining  (remaining),
    .cleared    (cleared)
`ifdef BLOCK_MAP_SCORE_EN
    , .score    (score)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state
  logic [2:0] m_cells [300];
  int         m_rem, m_idx, m_lvl, m_score;
  bit         m_busy, m_done, m_clr, m_acc;
  logic [2:0] m_code;
  int         checks, failures, exp_blk, n;
  bit         chk_en;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] pat(input int lvl, input int r, input int c);
    case (lvl)
      0:       return (r inside {[2:5]}) ? 3'b101 : ((r inside {[6:7]}) ? 3'b010 : 3'b000);
      1:       return (r inside {[2:9]} && ((r + c) % 2 == 0)) ? 3'b111 : 3'b000;
      2:       return (r == 4) ? 3'b001 : 3'b000;
      default: return 3'b100;
    endcase
  endfunction

  task automatic model_step();
    int k;
    logic [2:0] v;
    m_done = 0;
    m_clr  = 0;
    m_acc  = 0;
    if (level_load) begin
      m_busy = 1;
      m_idx  = 0;
      m_lvl  = int'(level_sel);
    end else if (m_busy) begin
      v = pat(m_lvl, m_idx / 10, m_idx % 10);
      m_cells[m_idx] = v;
      if (m_idx == 0) begin
        m_rem   = 0;
        m_score = 0;
      end
      if (v != 0) m_rem++;
      m_idx++;
      if (m_idx == 300) m_busy = 0;
    end else if (hit_valid) begin
      m_acc  = 1;
      m_done = 1;
      m_code = 3'b000;
      if (hit_row < 30 && hit_col < 10) begin
        k      = int'(hit_row) * 10 + int'(hit_col);
        v      = m_cells[k];
        m_code = v;
        if (v >= 1 && v <= 3) begin
          m_cells[k] = 3'b000;
          m_rem--;
          if (m_rem == 0) m_clr = 1;
          m_score = (m_score + 1 > 65535) ? 65535 : m_score + 1;
        end else if (v >= 4) begin
          m_cells[k] = (v == 3'b100) ? 3'b001 : v - 3'd4;
          m_score = (m_score + 2 > 65535) ? 65535 : m_score + 2;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic rd_chk(input string name, input int r, input int c, input int exp);
    sel_row = 5'(r);
    sel_col = 5'(c);
    #1;
    chk(name, block, exp);
    cyc();
  endtask

  task automatic do_load(input logic [1:0] lvl);
    int cnt;
    level_load = 1'b1;
    level_sel  = lvl;
    cyc();
    level_load = 1'b0;
    cnt = 0;
    while (busy && cnt < 1000) begin
      cyc();
      cnt++;
    end
    chk("load_cycles", cnt, 300);
  endtask

  task automatic do_hit(input string name, input int r, input int c, input int exp_code);
    int cnt;
    hit_valid = 1'b1;
    hit_row   = 5'(r);
    hit_col   = 5'(c);
    cnt = 0;
    do begin
      cyc();
      cnt++;
    end while (!m_acc && cnt < 50);
    hit_valid = 1'b0;
    chk({name, "_done"}, hit_done, 1);
    chk({name, "_code"}, hit_code, exp_code);
  endtask

  // Per-cycle comparison against the model, after inputs for the cycle have settled
  initial forever begin
    @(negedge clk);
    #2;
    if (chk_en) begin
      exp_blk = (sel_row < 30 && sel_col < 10) ? int'(m_cells[int'(sel_row) * 10 + int'(sel_col)]) : 0;
      chk("block", block, exp_blk);
      chk("busy", busy, m_busy);
      chk("hit_ready", hit_ready, !m_busy && !level_load);
      chk("hit_done", hit_done, m_done);
      if (m_done) chk("hit_code", hit_code, m_code);
      chk("cleared", cleared, m_clr);
      chk("remaining", remaining, m_rem);
`ifdef BLOCK_MAP_SCORE_EN
      chk("score", score, m_score);
`endif
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sel_row = '0; sel_col = '0; level_load = 1'b0; level_sel = '0;
    hit_valid = 1'b0; hit_row = '0; hit_col = '0;
    checks = 0; failures = 0; chk_en = 0;
    for (int i = 0; i < 300; i++) m_cells[i] = 3'b000;
    m_rem = 0; m_idx = 0; m_lvl = 0; m_score = 0; m_busy = 0; m_done = 0; m_clr = 0; m_acc = 0; m_code = 3'b000;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_remaining", remaining, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hit_ready", hit_ready, 1);
    chk("rst_hit_done", hit_done, 0);
    chk("rst_hit_code", hit_code, 0);
    chk("rst_cleared", cleared, 0);
    chk_en = 1;
    for (int i = 0; i < 300; i++) begin
      sel_row = 5'(i / 10);
      sel_col = 5'(i % 10);
      cyc();
    end

    do_load(2'd0);
    chk("L0_remaining", remaining, 60);
    rd_chk("L0_3_4", 3, 4, 3'b101);
    rd_chk("L0_6_0", 6, 0, 3'b010);
    rd_chk("L0_8_0", 8, 0, 3'b000);

    do_hit("hit_large", 3, 4, 3'b101);
    rd_chk("hit_large_cell", 3, 4, 3'b001);
    chk("hit_large_rem", remaining, 60);
    do_hit("hit_small", 3, 4, 3'b001);
    rd_chk("hit_small_cell", 3, 4, 3'b000);
    chk("hit_small_rem", remaining, 59);
`ifdef BLOCK_MAP_SCORE_EN
    chk("score_after_two", score, 3);
`endif

    do_load(2'd2);
    chk("L2_remaining", remaining, 10);
    for (int c = 0; c < 10; c++) begin
      do_hit($sformatf("row4_c%0d", c), 4, c, 3'b001);
      chk($sformatf("cleared_c%0d", c), cleared, (c == 9) ? 1 : 0);
    end
    chk("L2_empty", remaining, 0);
    do_hit("oor_hit", 31, 0, 3'b000);
    chk("oor_remaining", remaining, 0);
    chk("oor_cleared", cleared, 0);

    // Restart an L1 load with L3 in its 100th cycle, with a hit held pending
    level_load = 1'b1;
    level_sel  = 2'd1;
    cyc();
    level_load = 1'b0;
    repeat (99) cyc();
    chk("restart_busy_before", busy, 1);
    level_load = 1'b1;
    level_sel  = 2'd3;
    hit_valid  = 1'b1;
    hit_row    = 5'd0;
    hit_col    = 5'd1;
    cyc();
    level_load = 1'b0;
    n = 0;
    while (busy && n < 1000) begin
      cyc();
      n++;
    end
    chk("restart_cycles", n, 300);
    chk("restart_remaining", remaining, 300);
    chk("restart_no_early_hit", hit_done, 0);
    rd_chk("restart_0_1", 0, 1, 3'b100);
    hit_valid = 1'b0;
    chk("held_hit_done", hit_done, 1);
    chk("held_hit_code", hit_code, 3'b100);

    for (int i = 0; i < 4000; i++) begin
      sel_row = 5'($urandom_range(0, 31));
      sel_col = 5'($urandom_range(0, 15));
      if (!hit_valid && $urandom_range(0, 2) != 0) begin
        hit_valid = 1'b1;
        hit_row   = 5'(($urandom_range(0, 15) == 0) ? $urandom_range(30, 31) : $urandom_range(0, 29));
        hit_col   = 5'(($urandom_range(0, 15) == 0) ? $urandom_range(10, 31) : $urandom_range(0, 9));
      end
      level_load = ($urandom_range(0, 599) == 0);
      level_sel  = 2'($urandom_range(0, 3));
      cyc();
      level_load = 1'b0;
      if (m_acc) hit_valid = 1'b0;
    end

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
